// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb puzzle modules: state encodings and the
// version-to-target wire table.
package bomb_pkg;

  localparam int unsigned NUM_WIRES_DEF = 6;
  localparam int unsigned STATE_W       = 2;
  localparam int unsigned VIS_W         = 2;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_SETUP   = 2'b01;
  localparam logic [1:0] ST_ARMED   = 2'b10;
  localparam logic [1:0] ST_DEFUSED = 2'b11;

  // Wire that must be cut to defuse, selected by the latched puzzle version
  function automatic int unsigned target_idx(input logic [1:0] ver,
                                             input int unsigned num_wires);
    int unsigned idx;
    case (ver)
      2'd0:    idx = 2;
      2'd1:    idx = 0;
      2'd2:    idx = num_wires - 1;
      default: idx = 3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/wire_debounce.sv
// One wire: two-flop synchronizer followed by a stable-count debouncer.
// o_fall pulses for one cycle when the debounced level goes 1 -> 0.
module wire_debounce
  import bomb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  // Accept the new level on the DEBOUNCE_CYCLES-th consecutive differing sample
  assign w_accept = (r_sync2 != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_fall  <= w_accept && r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/wires_module.sv
// Wires puzzle: debounces each wire, arms once all wires are intact, then
// defuses on a lone cut of the version's target wire and strikes on wrong cuts.
module wires_module
  import bomb_pkg::*;
#(
  parameter int unsigned NUM_WIRES       = NUM_WIRES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           seed,
  input  logic [NUM_WIRES-1:0] wires_in,
  output logic [VIS_W-1:0]     module_visuals,
  output logic [STATE_W-1:0]   module_state,
  output logic                 ready,
  output logic                 module_defused,
  output logic                 strike
);

  logic [NUM_WIRES-1:0] w_level;
  logic [NUM_WIRES-1:0] w_fall;
  logic [NUM_WIRES-1:0] w_tmask;
  logic                 w_wrong;
  logic                 w_tgt;
  logic                 w_en_rise;
  logic                 w_unused_seed;
  int unsigned          w_tidx;

  logic [1:0] r_state, w_state_nxt;
  logic [1:0] r_vis, w_vis_nxt;
  logic       r_tcut, w_tcut_nxt;
  logic       r_strike, w_strike_nxt;
  logic       r_ready, w_ready_nxt;
  logic       r_defused, w_defused_nxt;
  logic       r_en_prev;
  logic       r_en_valid;

  for (genvar g = 0; g < NUM_WIRES; g++) begin : g_wire
    wire_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clock),
      .rst_n   (reset),
      .i_raw   (wires_in[g]),
      .o_level (w_level[g]),
      .o_fall  (w_fall[g])
    );
  end

  assign w_unused_seed = ^seed[7:2];
  assign w_tidx  = target_idx(r_vis, NUM_WIRES);
  assign w_tmask = (w_tidx < NUM_WIRES) ? (NUM_WIRES'(1) << w_tidx) : '0;
  assign w_wrong = |(w_fall & ~w_tmask);
  assign w_tgt   = |(w_fall & w_tmask);
  // r_en_valid masks the first post-reset sample so a held-high enable is not a rise
  assign w_en_rise = enable && !r_en_prev && r_en_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_vis      <= '0;
      r_tcut     <= 1'b0;
      r_strike   <= 1'b0;
      r_ready    <= 1'b0;
      r_defused  <= 1'b0;
      r_en_prev  <= 1'b0;
      r_en_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_vis      <= w_vis_nxt;
      r_tcut     <= w_tcut_nxt;
      r_strike   <= w_strike_nxt;
      r_ready    <= w_ready_nxt;
      r_defused  <= w_defused_nxt;
      r_en_prev  <= enable;
      r_en_valid <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_vis_nxt    = r_vis;
    w_tcut_nxt   = r_tcut;
    w_strike_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_tcut_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_en_rise) begin
            w_state_nxt = ST_SETUP;
            w_vis_nxt   = seed[1:0];
            w_tcut_nxt  = 1'b0;
          end
        end
        ST_SETUP: begin
          if (&w_level) w_state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          // Once the target went down alongside a wrong cut, defuse is no longer possible
          if (w_wrong) w_strike_nxt = 1'b1;
          if (w_tgt)   w_tcut_nxt   = 1'b1;
          if (w_tgt && !w_wrong && !r_tcut) w_state_nxt = ST_DEFUSED;
        end
        default: ;
      endcase
    end
    w_ready_nxt   = (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_DEFUSED);
    w_defused_nxt = (w_state_nxt == ST_DEFUSED);
  end

  assign module_visuals = r_vis;
  assign module_state   = r_state;
  assign ready          = r_ready;
  assign module_defused = r_defused;
  assign strike         = r_strike;

endmodule
